// File: rtl/genius.sv
// genius: four-colour memory game core with FOLLOW and ADD ("Mando eu") modes.
// Define INPUT_ECHO_EN to mirror the registered buttons on the LEDs while waiting for player input.
package genius_pkg;
    typedef enum logic {GAMEMODE_FOLLOW = 1'b0, GAMEMODE_ADD = 1'b1} gamemode_t;
    typedef enum logic [1:0] {DIFF_EASY = 2'd0, DIFF_MEDIUM = 2'd1, DIFF_HARD = 2'd2} difficulty_t;
    typedef enum logic {VELOCITY_SLOW = 1'b0, VELOCITY_FAST = 1'b1} velocity_t;
    typedef enum logic [1:0] {COLOR_GREEN = 2'd0, COLOR_RED = 2'd1, COLOR_BLUE = 2'd2, COLOR_YELLOW = 2'd3} color_t;
endpackage

module genius
    import genius_pkg::*;
#(
    parameter int DATA_WIDTH     = 4,
    parameter int SLOW_ON_CYCLES = 40,
    parameter int FAST_ON_CYCLES = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        btn_green,
    input  logic        btn_red,
    input  logic        btn_blue,
    input  logic        btn_yellow,
    input  gamemode_t   gm_switch,
    input  difficulty_t diff_switch,
    input  velocity_t   speed_switch,
    output logic        win,
    output logic        lost,
    output logic        led_red,
    output logic        led_blue,
    output logic        led_green,
    output logic        led_yellow
);
    localparam int MAXLEN = 2 ** DATA_WIDTH;
    localparam int LW     = DATA_WIDTH + 1;
    localparam int TW     = $clog2(SLOW_ON_CYCLES > FAST_ON_CYCLES ? SLOW_ON_CYCLES : FAST_ON_CYCLES) + 1;
    localparam int T_EASY = 8 < MAXLEN ? 8 : MAXLEN;
    localparam int T_MED  = 12 < MAXLEN ? 12 : MAXLEN;
`ifdef INPUT_ECHO_EN
    localparam logic ECHO = 1'b1;
`else
    localparam logic ECHO = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE, ST_GEN, ST_SHOW_LEDS, ST_PLAYER_IN, ST_EVAL, ST_ADD_COLOR, ST_END
    } state_t;

    state_t                current_s, next_s;
    color_t                game_seq [0:MAXLEN-1];
    logic [LW-1:0]         len, len_n, target;
    logic [DATA_WIDTH-1:0] idx, idx_n;
    logic [TW-1:0]         tmr, tmr_n, on_len, off_len;
    logic                  phase, phase_n, last;
    logic                  player1_turn, p1_n, add_color_mode, acm_n, win_n, lost_n;
    gamemode_t             gm, gm_n;
    difficulty_t           diff, diff_n;
    velocity_t             speed, speed_n;
    color_t                col, col_n, seq_wd, press_col;
    logic                  seq_we;
    logic [3:0]            btn_r, btn_d, press, leds, leds_n;
    logic                  start_r, start_d, start_edge;
    logic [15:0]           lfsr;

    assign press      = btn_r & ~btn_d;
    assign start_edge = start_r & ~start_d;
    assign press_col  = press[0] ? COLOR_GREEN : press[1] ? COLOR_RED : press[2] ? COLOR_BLUE : COLOR_YELLOW;
    assign on_len     = speed == VELOCITY_FAST ? TW'(FAST_ON_CYCLES) : TW'(SLOW_ON_CYCLES);
    assign off_len    = on_len >> 1;
    assign target     = diff == DIFF_EASY ? LW'(T_EASY) : diff == DIFF_MEDIUM ? LW'(T_MED) : LW'(MAXLEN);
    assign last       = {1'b0, idx} == len - 1'b1;
    assign {led_yellow, led_blue, led_red, led_green} = leds;

    always_comb begin
        next_s  = current_s;
        len_n   = len;
        idx_n   = idx;
        tmr_n   = tmr;
        phase_n = phase;
        p1_n    = player1_turn;
        acm_n   = add_color_mode;
        win_n   = win;
        lost_n  = lost;
        gm_n    = gm;
        diff_n  = diff;
        speed_n = speed;
        col_n   = col;
        seq_we  = 1'b0;
        seq_wd  = color_t'(lfsr[1:0]);
        leds_n  = 4'b0;
        case (current_s)
            ST_IDLE, ST_END: begin
                leds_n = {4{win}};
                if (start_edge) begin
                    gm_n    = gm_switch;
                    diff_n  = diff_switch;
                    speed_n = speed_switch;
                    len_n   = '0;
                    idx_n   = '0;
                    win_n   = 1'b0;
                    lost_n  = 1'b0;
                    p1_n    = 1'b1;
                    acm_n   = 1'b0;
                    next_s  = ST_GEN;
                end
            end
            ST_GEN: begin
                seq_we  = 1'b1;
                len_n   = len + 1'b1;
                idx_n   = '0;
                tmr_n   = '0;
                phase_n = 1'b0;
                next_s  = ST_SHOW_LEDS;
            end
            ST_SHOW_LEDS: begin
                leds_n = phase ? 4'b0 : 4'b0001 << game_seq[idx];
                tmr_n  = tmr + 1'b1;
                if (!phase && tmr == on_len - 1'b1) begin
                    tmr_n   = '0;
                    phase_n = 1'b1;
                end else if (phase && tmr == off_len - 1'b1) begin
                    tmr_n   = '0;
                    phase_n = 1'b0;
                    idx_n   = last ? '0 : idx + 1'b1;
                    next_s  = last ? ST_PLAYER_IN : ST_SHOW_LEDS;
                end
            end
            ST_PLAYER_IN: begin
                leds_n = ECHO ? btn_r : 4'b0;
                if (|press) begin
                    col_n  = press_col;
                    next_s = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (col != game_seq[idx]) begin
                    lost_n = 1'b1;
                    next_s = ST_END;
                end else if (!last) begin
                    idx_n  = idx + 1'b1;
                    next_s = ST_PLAYER_IN;
                end else if (gm == GAMEMODE_FOLLOW) begin
                    win_n  = len == target;
                    next_s = len == target ? ST_END : ST_GEN;
                end else begin
                    p1_n   = !player1_turn;
                    acm_n  = 1'b1;
                    next_s = ST_ADD_COLOR;
                end
            end
            ST_ADD_COLOR: begin
                leds_n = ECHO ? btn_r : 4'b0;
                if (|press) begin
                    seq_we  = 1'b1;
                    seq_wd  = press_col;
                    len_n   = len + 1'b1;
                    acm_n   = 1'b0;
                    idx_n   = '0;
                    tmr_n   = '0;
                    phase_n = 1'b0;
                    win_n   = len_n == LW'(MAXLEN);
                    next_s  = len_n == LW'(MAXLEN) ? ST_END : ST_SHOW_LEDS;
                end
            end
            default: next_s = ST_IDLE;
        endcase
    end

    // Sequence memory needs no reset: only entries below len are ever read.
    always_ff @(posedge clk)
        if (seq_we) game_seq[len[DATA_WIDTH-1:0]] <= seq_wd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            current_s      <= ST_IDLE;
            len            <= '0;
            idx            <= '0;
            tmr            <= '0;
            phase          <= 1'b0;
            player1_turn   <= 1'b1;
            add_color_mode <= 1'b0;
            win            <= 1'b0;
            lost           <= 1'b0;
            gm             <= GAMEMODE_FOLLOW;
            diff           <= DIFF_EASY;
            speed          <= VELOCITY_SLOW;
            col            <= COLOR_GREEN;
            leds           <= 4'b0;
            btn_r          <= 4'b0;
            btn_d          <= 4'b0;
            start_r        <= 1'b0;
            start_d        <= 1'b0;
            lfsr           <= 16'hACE1;
        end else begin
            current_s      <= next_s;
            len            <= len_n;
            idx            <= idx_n;
            tmr            <= tmr_n;
            phase          <= phase_n;
            player1_turn   <= p1_n;
            add_color_mode <= acm_n;
            win            <= win_n;
            lost           <= lost_n;
            gm             <= gm_n;
            diff           <= diff_n;
            speed          <= speed_n;
            col            <= col_n;
            leds           <= leds_n;
            btn_r          <= {btn_yellow, btn_blue, btn_red, btn_green};
            btn_d          <= btn_r;
            start_r        <= start;
            start_d        <= start_r;
            lfsr           <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end
endmodule

// File: tb/tb_genius.sv
// tb_genius: plays the genius game core through its buttons and checks it against a sequence model.
module tb_genius;
    import genius_pkg::*;

    localparam int S_IDLE = 0, S_GEN = 1, S_SHOW = 2, S_PIN = 3, S_EVAL = 4, S_ADD = 5, S_END = 6;

    logic        clk = 0, rst_n = 0, start = 0;
    logic [3:0]  btns = 4'b0;
    gamemode_t   gm = GAMEMODE_FOLLOW;
    difficulty_t diff = DIFF_EASY;
    velocity_t   spd = VELOCITY_SLOW;
    logic        win, lost, led_red, led_blue, led_green, led_yellow;
    logic [15:0] m_lfsr;
    logic [1:0]  model_seq[$];
    int          checks = 0, errors = 0;

    genius dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .btn_green(btns[0]), .btn_red(btns[1]), .btn_blue(btns[2]), .btn_yellow(btns[3]),
        .gm_switch(gm), .diff_switch(diff), .speed_switch(spd),
        .win(win), .lost(lost),
        .led_red(led_red), .led_blue(led_blue), .led_green(led_green), .led_yellow(led_yellow)
    );

    always #5 clk = ~clk;

    // Reference LFSR (x^16+x^14+x^13+x^11+1, right-shifting) and the colour each generation step should pick.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) m_lfsr <= 16'hACE1;
        else m_lfsr <= (m_lfsr >> 1) | (16'(m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5]) << 15);

    always @(posedge clk)
        if (rst_n && dut.current_s == 3'd1) model_seq.push_back(m_lfsr[1:0]);

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] leds();
        return {led_yellow, led_blue, led_red, led_green};
    endfunction

    task automatic wait_state(input int s, input int max, input string nm);
        int n = 0;
        while (int'(dut.current_s) != s && n < max) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (int'(dut.current_s) != s) begin
            errors++;
            $display("FAIL %s: state %0d after %0d cycles, wanted %0d", nm, dut.current_s, n, s);
        end
    endtask

    task automatic do_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic new_game(input gamemode_t g, input difficulty_t d, input velocity_t s);
        gm = g; diff = d; spd = s;
        model_seq.delete();
        start = 1;
        repeat (2) @(negedge clk);
        start = 0;
    endtask

    task automatic press(input logic [1:0] c);
        repeat (3) @(negedge clk);
        btns[c] = 1;
        repeat (3) @(negedge clk);
        btns = 4'b0;
    endtask

    // Decodes the LED display into on-runs and gaps until the core asks for input.
    task automatic capture_show(input string nm);
        int on_len = (spd == VELOCITY_FAST) ? 20 : 40;
        int run = 0, n_on = 0, bad = 0;
        logic [3:0] prev = 0, v;
        logic [31:0] got = 0, exp = 0;
        bit seen = 0, done = 0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(negedge clk);
            v = leds();
            if (v == prev) run++;
            else begin
                if (prev != 0 && run != on_len) bad++;
                if (prev == 0 && seen && run != on_len / 2) bad++;
                if (v != 0) begin
                    if (!$onehot(v)) bad++;
                    if (n_on < 16) got[2*n_on +: 2] = v[1] ? 2'd1 : v[2] ? 2'd2 : v[3] ? 2'd3 : 2'd0;
                    n_on++;
                    seen = 1;
                end
                prev = v;
                run = 1;
            end
            done = seen && int'(dut.current_s) == S_PIN;
        end
        if (prev != 0 || run != on_len / 2) bad++;
        for (int i = 0; i < model_seq.size() && i < 16; i++) exp[2*i +: 2] = model_seq[i];
        checks += 4;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: display never reached input state (state %0d)", nm, dut.current_s);
        end
        if (n_on != model_seq.size()) begin
            errors++;
            $display("FAIL %s count: %0d colours shown, wanted %0d", nm, n_on, model_seq.size());
        end
        if (got !== exp) begin
            errors++;
            $display("FAIL %s colours: shown %h, wanted %h", nm, got, exp);
        end
        if (bad != 0 || dut.len !== 5'(model_seq.size())) begin
            errors++;
            $display("FAIL %s timing/len: %0d bad runs, len %0d wanted %0d", nm, bad, dut.len, model_seq.size());
        end
    endtask

    task automatic play_round(input bit cap, input string nm);
        int n = model_seq.size();
        for (int i = 0; i < n; i++)
            if (cap && i == n - 1)
                fork
                    press(model_seq[i]);
                    capture_show(nm);
                join
            else press(model_seq[i]);
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (5) @(negedge clk);
        checks++;
        if ({win, lost, leds()} !== 6'b0 || int'(dut.current_s) != S_IDLE || dut.len !== 5'd0
            || dut.player1_turn !== 1'b1 || dut.add_color_mode !== 1'b0) begin
            errors++;
            $display("FAIL reset: win %b lost %b leds %b state %0d len %0d p1 %b acm %b, wanted all 0/idle, p1 1",
                     win, lost, leds(), dut.current_s, dut.len, dut.player1_turn, dut.add_color_mode);
        end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_show_timing();
        new_game(GAMEMODE_FOLLOW, DIFF_EASY, VELOCITY_SLOW);
        checks++;
        if (int'(dut.current_s) != S_GEN || dut.len !== 5'd0) begin
            errors++;
            $display("FAIL start_to_gen: state %0d len %0d, wanted %0d and 0", dut.current_s, dut.len, S_GEN);
        end
        capture_show("show_first");
    endtask

    task automatic test_follow_win();
        gm = GAMEMODE_ADD;
        diff = DIFF_HARD;
        for (int r = 0; r < 8 && model_seq.size() < 8; r++) play_round(1, "follow_round");
        play_round(0, "follow_last");
        wait_state(S_END, 20, "follow_win_end");
        repeat (2) @(negedge clk);
        checks++;
        if (win !== 1'b1 || lost !== 1'b0 || dut.len !== 5'd8 || leds() !== 4'hF) begin
            errors++;
            $display("FAIL follow_win: win %b lost %b len %0d leds %b, wanted 1 0 8 1111", win, lost, dut.len, leds());
        end
    endtask

    task automatic test_follow_lose();
        logic [1:0] w;
        do_reset();
        new_game(GAMEMODE_FOLLOW, DIFF_MEDIUM, VELOCITY_FAST);
        capture_show("lose_show");
        for (int r = 0; r < 2; r++) play_round(1, "lose_round");
        press(model_seq[0]);
        w = model_seq[1] + 2'd1;
        repeat (3) @(negedge clk);
        btns[w] = 1;
        wait_state(S_EVAL, 10, "lose_eval");
        @(negedge clk);
        checks++;
        if (int'(dut.current_s) != S_END || lost !== 1'b1 || win !== 1'b0 || dut.len !== 5'd3) begin
            errors++;
            $display("FAIL follow_lose: state %0d lost %b win %b len %0d, wanted %0d 1 0 3",
                     dut.current_s, lost, win, dut.len, S_END);
        end
        btns = 4'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (leds() !== 4'h0) begin
            errors++;
            $display("FAIL lost_leds: leds %b, wanted 0000", leds());
        end
    endtask

    task automatic test_restart();
        new_game(GAMEMODE_FOLLOW, DIFF_EASY, VELOCITY_FAST);
        checks++;
        if (int'(dut.current_s) != S_GEN || win !== 1'b0 || lost !== 1'b0 || dut.len !== 5'd0) begin
            errors++;
            $display("FAIL restart: state %0d win %b lost %b len %0d, wanted %0d 0 0 0",
                     dut.current_s, win, lost, dut.len, S_GEN);
        end
        capture_show("restart_show");
    endtask

    task automatic test_priority();
        int es;
        do_reset();
        new_game(GAMEMODE_FOLLOW, DIFF_EASY, VELOCITY_FAST);
        capture_show("prio_show");
        repeat (3) @(negedge clk);
        btns = 4'hF;
        wait_state(S_EVAL, 10, "prio_eval");
        @(negedge clk);
        es = (model_seq[0] == 2'd0) ? S_GEN : S_END;
        checks++;
        if (int'(dut.current_s) != es || lost !== (model_seq[0] != 2'd0)) begin
            errors++;
            $display("FAIL priority: state %0d lost %b, wanted %0d %b (first colour %0d)",
                     dut.current_s, lost, es, model_seq[0] != 2'd0, model_seq[0]);
        end
        btns = 4'b0;
    endtask

    task automatic test_hold();
        do_reset();
        new_game(GAMEMODE_FOLLOW, DIFF_EASY, VELOCITY_FAST);
        capture_show("hold_show");
        repeat (3) @(negedge clk);
        btns[model_seq[0]] = 1;
        capture_show("hold_show2");
        repeat (5) @(negedge clk);
        checks++;
        if (int'(dut.current_s) != S_PIN || dut.idx !== 4'd0) begin
            errors++;
            $display("FAIL hold_once: state %0d idx %0d, wanted %0d 0", dut.current_s, dut.idx, S_PIN);
        end
        btns = 4'b0;
    endtask

    task automatic test_add_mode();
        logic [1:0] c;
        logic exp_p1 = 1;
        do_reset();
        new_game(GAMEMODE_ADD, DIFF_EASY, VELOCITY_FAST);
        capture_show("add_show");
        start = 1;
        repeat (2) @(negedge clk);
        start = 0;
        @(negedge clk);
        checks++;
        if (int'(dut.current_s) != S_PIN || dut.len !== 5'd1) begin
            errors++;
            $display("FAIL start_ignored: state %0d len %0d, wanted %0d 1", dut.current_s, dut.len, S_PIN);
        end
        for (int r = 0; r < 16 && model_seq.size() < 16; r++) begin
            play_round(0, "add_replay");
            wait_state(S_ADD, 20, "add_color_state");
            exp_p1 = ~exp_p1;
            checks++;
            if (dut.add_color_mode !== 1'b1 || dut.player1_turn !== exp_p1) begin
                errors++;
                $display("FAIL add_turn: acm %b p1 %b, wanted 1 %b", dut.add_color_mode, dut.player1_turn, exp_p1);
            end
            c = (r == 0) ? 2'd2 : 2'($urandom_range(3));
            model_seq.push_back(c);
            if (model_seq.size() == 16) begin
                press(c);
                wait_state(S_END, 20, "add_win_end");
                repeat (2) @(negedge clk);
                checks++;
                if (win !== 1'b1 || lost !== 1'b0 || dut.len !== 5'd16 || leds() !== 4'hF) begin
                    errors++;
                    $display("FAIL add_win: win %b lost %b len %0d leds %b, wanted 1 0 16 1111",
                             win, lost, dut.len, leds());
                end
            end else begin
                fork
                    press(c);
                    capture_show("add_show_round");
                join
                checks++;
                if (dut.add_color_mode !== 1'b0 || dut.game_seq[model_seq.size() - 1] !== c) begin
                    errors++;
                    $display("FAIL add_store: acm %b stored %0d, wanted 0 %0d",
                             dut.add_color_mode, dut.game_seq[model_seq.size() - 1], c);
                end
            end
        end
    endtask

    task automatic test_reset_mid_show();
        int n = 0;
        do_reset();
        new_game(GAMEMODE_FOLLOW, DIFF_EASY, VELOCITY_SLOW);
        while (leds() == 4'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        rst_n = 0;
        #1;
        checks++;
        if (n >= 200 || {win, lost, leds()} !== 6'b0 || int'(dut.current_s) != S_IDLE || dut.len !== 5'd0) begin
            errors++;
            $display("FAIL reset_mid_show: waited %0d, win %b lost %b leds %b state %0d len %0d, wanted all 0",
                     n, win, lost, leds(), dut.current_s, dut.len);
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_show_timing();
        test_follow_win();
        test_follow_lose();
        test_restart();
        test_priority();
        test_hold();
        test_add_mode();
        test_reset_mid_show();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
